// File: rtl/controle_temporizacao_pkg.sv
// Shared definitions for the game timing/config scheduler.
package controle_temporizacao_pkg;

  // Interval phase encoding, also exported on db_fase.
  typedef enum logic [1:0] {
    FASE_IDLE   = 2'd0,
    FASE_ON     = 2'd1,
    FASE_OFF    = 2'd2,
    FASE_ESPERA = 2'd3
  } fase_t;

  // Default interval lengths, in ticks.
  localparam int unsigned LARGURA_DEF      = 16;
  localparam int unsigned PRESCALER_DEF    = 1000;
  localparam int unsigned T_ON_FACIL_DEF   = 500;
  localparam int unsigned T_ON_DIFICIL_DEF = 250;
  localparam int unsigned T_OFF_DEF        = 250;
  localparam int unsigned T_TIMEOUT_DEF    = 3000;

  // Priority decode of the control-unit requests: ledsOn > ledsOff > espera > idle.
  function automatic fase_t decodifica_fase(input logic on, input logic off,
                                            input logic espera);
    if (on) begin
      return FASE_ON;
    end else if (off) begin
      return FASE_OFF;
    end else if (espera) begin
      return FASE_ESPERA;
    end
    return FASE_IDLE;
  endfunction

endpackage

// File: rtl/controle_temporizacao_gerador_tick.sv
// Prescaler: counts clock cycles and pulses tick once every PRESCALER cycles.
module controle_temporizacao_gerador_tick #(
  parameter int unsigned PRESCALER = 1000
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  output logic tick
);

  localparam int unsigned W = (PRESCALER > 1) ? $clog2(PRESCALER) : 1;
  localparam logic [W-1:0] PRE_MAX = W'(PRESCALER - 1);

  logic [W-1:0] pre_q;
  logic [W-1:0] pre_d;
  logic         wrap;

  assign wrap = (pre_q == PRE_MAX);

  // Tick is suppressed in the clear cycle so a fresh interval starts from a full period.
  assign tick = wrap & ~clear;

  // Next prescaler value: restart on clear, otherwise count and wrap.
  always_comb begin
    pre_d = pre_q + W'(1);
    if (clear || wrap) begin
      pre_d = '0;
    end
  end

  // Prescaler register with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      pre_q <= '0;
    end else begin
      pre_q <= pre_d;
    end
  end

endmodule

// File: rtl/controle_temporizacao.sv
// Shared interval timer for LED on/off and play timeout, plus game config latching.
module controle_temporizacao
  import controle_temporizacao_pkg::*;
#(
  parameter int unsigned LARGURA      = LARGURA_DEF,
  parameter int unsigned PRESCALER    = PRESCALER_DEF,
  parameter int unsigned T_ON_FACIL   = T_ON_FACIL_DEF,
  parameter int unsigned T_ON_DIFICIL = T_ON_DIFICIL_DEF,
  parameter int unsigned T_OFF        = T_OFF_DEF,
  parameter int unsigned T_TIMEOUT    = T_TIMEOUT_DEF
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               iniciar,
  input  logic               pronto,
  input  logic               nivel,
  input  logic [1:0]         memoria,
  input  logic               estado_ledsOn,
  input  logic               estado_ledsOff,
  input  logic               estado_espera,
  output logic               fimLedsOn,
  output logic               fimLedsOff,
  output logic               timeout,
  output logic               nivelChange,
  output logic               memoriaChange,
  output logic               nivel_reg,
  output logic [1:0]         memoria_reg,
  output logic [1:0]         db_fase,
  output logic [LARGURA-1:0] db_contagem
);

  fase_t              fase_q, fase_d, fase_dec;
  logic [LARGURA-1:0] cnt_q, cnt_d;
  logic               entrada;
  logic               tick;
  logic               expirou;
  logic               ativo_q, ativo_d;
  logic               nivel_q, nivel_d;
  logic [1:0]         memoria_q, memoria_d;

  assign fase_dec = decodifica_fase(estado_ledsOn, estado_ledsOff, estado_espera);
  assign entrada  = (fase_dec != fase_q);

  controle_temporizacao_gerador_tick #(
    .PRESCALER(PRESCALER)
  ) u_gerador_tick (
    .clock(clock),
    .reset(reset),
    .clear(entrada),
    .tick (tick)
  );

  // Interval sequencing: reload on phase entry, count down ticks while the phase holds.
  always_comb begin
    fase_d = fase_q;
    cnt_d  = cnt_q;
    if (entrada) begin
      fase_d = fase_dec;
      unique case (fase_dec)
        FASE_ON:     cnt_d = nivel_q ? LARGURA'(T_ON_DIFICIL) : LARGURA'(T_ON_FACIL);
        FASE_OFF:    cnt_d = LARGURA'(T_OFF);
        FASE_ESPERA: cnt_d = LARGURA'(T_TIMEOUT);
        default:     cnt_d = '0;
      endcase
    end else if (tick && (cnt_q != '0)) begin
      cnt_d = cnt_q - LARGURA'(1);
    end
  end

  // Config latching: iniciar takes priority over pronto.
  always_comb begin
    ativo_d   = ativo_q;
    nivel_d   = nivel_q;
    memoria_d = memoria_q;
    if (iniciar) begin
      ativo_d   = 1'b1;
      nivel_d   = nivel;
      memoria_d = memoria;
    end else if (pronto) begin
      ativo_d = 1'b0;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      fase_q    <= FASE_IDLE;
      cnt_q     <= '0;
      ativo_q   <= 1'b0;
      nivel_q   <= 1'b0;
      memoria_q <= 2'b00;
    end else begin
      fase_q    <= fase_d;
      cnt_q     <= cnt_d;
      ativo_q   <= ativo_d;
      nivel_q   <= nivel_d;
      memoria_q <= memoria_d;
    end
  end

  // Expiry is a level held while the same request stays high with the count at zero.
  always_comb begin
    expirou    = ~entrada & (cnt_q == '0);
    fimLedsOn  = expirou & (fase_q == FASE_ON);
    fimLedsOff = expirou & (fase_q == FASE_OFF);
    timeout    = expirou & (fase_q == FASE_ESPERA);
  end

  assign nivelChange   = ativo_q & (nivel != nivel_q);
  assign memoriaChange = ativo_q & (memoria != memoria_q);
  assign nivel_reg     = nivel_q;
  assign memoria_reg   = memoria_q;
  assign db_fase       = fase_q;
  assign db_contagem   = cnt_q;

endmodule
